// File: rtl/rgb_mixer_pkg.sv
// Shared definitions for the RGB mixer encoder input path.
// Provides the default count width, the {A,B} quadrature pair type,
// the four Gray-code state constants and the x1 step decode helpers.
package rgb_mixer_pkg;

  localparam int unsigned COUNT_W = 8;

  // Quadrature pair, bit order {A,B}
  typedef logic [1:0] quad_t;

  localparam quad_t Q_00 = 2'b00;
  localparam quad_t Q_10 = 2'b10;
  localparam quad_t Q_11 = 2'b11;
  localparam quad_t Q_01 = 2'b01;

  // CW step: A rises while B is low
  function automatic logic is_inc(input quad_t prev, input quad_t cur);
    return (prev == Q_00) && (cur == Q_10);
  endfunction

  // CCW step: A rises while B is high
  function automatic logic is_dec(input quad_t prev, input quad_t cur);
    return (prev == Q_01) && (cur == Q_11);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit synchroniser with asynchronous active-high reset.
// Ports:
//   clk - destination clock
//   rst - async active-high reset, clears every stage
//   d   - asynchronous input
//   q   - synchronised output (last flop of the chain)
module sync_2ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift chain; new sample enters at bit 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/rotary_encoder.sv
// Quadrature decoder for a mechanical rotary encoder.
// Synchronises A/B, decodes one step per detent (x1) and keeps an
// 8-bit saturating value feeding one colour-channel intensity.
// Ports:
//   clk   - system clock, rising edge
//   rst   - async active-high reset
//   A, B  - encoder channels, asynchronous to clk
//   count - current encoder value, unsigned, registered
module rotary_encoder
  import rgb_mixer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned COUNT_W     = rgb_mixer_pkg::COUNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               A,
  input  logic               B,
  output logic [COUNT_W-1:0] count
);

  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  logic               a_s;
  logic               b_s;
  quad_t              cur;
  quad_t              prev;
  logic [COUNT_W-1:0] next_count;

  sync_2ff #(.STAGES(SYNC_STAGES)) u_sync_a (
    .clk (clk),
    .rst (rst),
    .d   (A),
    .q   (a_s)
  );

  sync_2ff #(.STAGES(SYNC_STAGES)) u_sync_b (
    .clk (clk),
    .rst (rst),
    .d   (B),
    .q   (b_s)
  );

  assign cur = {a_s, b_s};

  // Previous-state register; tracks every transition, legal or not
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= Q_00;
    end else begin
      prev <= cur;
    end
  end

  // Saturating step; illegal double-bit changes match neither pattern
  always_comb begin
    next_count = count;
    if (is_inc(prev, cur) && (count != COUNT_MAX)) begin
      next_count = count + COUNT_W'(1);
    end else if (is_dec(prev, cur) && (count != '0)) begin
      next_count = count - COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= next_count;
    end
  end

endmodule

// File: tb/tb_rotary_encoder.sv
module tb_rotary_encoder;

  localparam int unsigned SYNC = 2;

  logic       clk;
  logic       rst;
  logic       A;
  logic       B;
  logic [7:0] count;

  int unsigned n_tests;
  int unsigned n_fail;

  rotary_encoder #(.SYNC_STAGES(SYNC), .COUNT_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: record what the pins held at each rising edge; a
  // sample influences count SYNC edges after it was taken. Each step is
  // judged from the pin pair it follows using the detent rules.
  logic [1:0] hist[$];
  logic [1:0] m_prev;
  logic [1:0] m_cur;
  int         m_count;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist.delete();
      m_prev  = 2'b00;
      m_count = 0;
    end else begin
      hist.push_back({A, B});
      if (hist.size() > SYNC) begin
        m_cur = hist.pop_front();
        if (m_prev == 2'b00 && m_cur == 2'b10 && m_count < 255) m_count = m_count + 1;
        if (m_prev == 2'b01 && m_cur == 2'b11 && m_count > 0)   m_count = m_count - 1;
        m_prev = m_cur;
      end
    end
  end

  task automatic check(input string name, input int exp);
    n_tests++;
    if (count !== 8'(exp)) begin
      n_fail++;
      $display("FAIL %s: count=%0d expected=%0d at %0t", name, count, exp, $time);
    end
  endtask

  // One clock with the pins held; also compares against the model
  task automatic cyc(input logic a, input logic b);
    @(negedge clk);
    A = a;
    B = b;
    @(posedge clk);
    #1;
    check("model", m_count);
  endtask

  task automatic cw_detent();
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b1); cyc(1'b0, 1'b1); cyc(1'b0, 1'b0);
  endtask

  task automatic ccw_detent();
    cyc(1'b0, 1'b1); cyc(1'b1, 1'b1); cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);
  endtask

  typedef struct {
    logic       a;
    logic       b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[19];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    A   = 1'b0;
    B   = 1'b0;

    vecs[0]  = '{1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 1'b0, 8'd1};
    vecs[2]  = '{1'b1, 1'b1, 8'd1};
    vecs[3]  = '{1'b0, 1'b1, 8'd1};
    vecs[4]  = '{1'b0, 1'b0, 8'd1};
    vecs[5]  = '{1'b1, 1'b0, 8'd2};
    vecs[6]  = '{1'b0, 1'b0, 8'd2};
    vecs[7]  = '{1'b0, 1'b1, 8'd2};
    vecs[8]  = '{1'b1, 1'b1, 8'd1};
    vecs[9]  = '{1'b1, 1'b0, 8'd1};
    vecs[10] = '{1'b0, 1'b0, 8'd1};
    vecs[11] = '{1'b0, 1'b1, 8'd1};
    vecs[12] = '{1'b1, 1'b1, 8'd0};
    vecs[13] = '{1'b0, 1'b1, 8'd0};
    vecs[14] = '{1'b1, 1'b1, 8'd0};
    vecs[15] = '{1'b0, 1'b0, 8'd0};
    vecs[16] = '{1'b1, 1'b1, 8'd0};
    vecs[17] = '{1'b0, 1'b0, 8'd0};
    vecs[18] = '{1'b1, 1'b0, 8'd1};

    // Reset held for 20 ns
    #20;
    check("reset_held", 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    check("reset_release", 0);

    // One CW detent with latency: count moves on the second edge after A is sampled
    cyc(1'b1, 1'b0); check("cw_lat0", 0);
    cyc(1'b1, 1'b1); check("cw_lat1", 0);
    cyc(1'b0, 1'b1); check("cw_lat2", 1);
    cyc(1'b0, 1'b0); check("cw_hold", 1);
    flush();         check("cw_done", 1);

    // One CCW detent back to zero
    ccw_detent();
    flush();
    check("ccw_done", 0);

    // Table: each pin pair held three clocks, then count compared
    for (int i = 0; i < 19; i++) begin
      for (int j = 0; j < 3; j++) cyc(vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d", i), int'(vecs[i].exp));
    end
    flush();
    check("vec_end", 1);

    // Saturation at both ends
    for (int i = 0; i < 260; i++) cw_detent();
    flush();
    check("sat_hi", 255);
    cw_detent();
    flush();
    check("sat_hi_extra", 255);
    for (int i = 0; i < 300; i++) ccw_detent();
    flush();
    check("sat_lo", 0);
    ccw_detent();
    flush();
    check("sat_lo_extra", 0);

    // Zero-width glitches away from the clock edge
    cw_detent(); cw_detent();
    flush();
    check("glitch_pre", 2);
    for (int i = 0; i < 30; i++) begin
      A = 1'b1; B = 1'b1; A = 1'b0; B = 1'b0;
    end
    B = 1'b1; A = 1'b1; B = 1'b0; A = 1'b0;
    flush();
    check("glitch_post", 2);

    // Illegal transitions: both pins change together
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    check("illegal_up", 2);
    cyc(1'b0, 1'b0);
    flush();
    check("illegal_down", 2);

    // Async reset mid-sequence at count=5
    cw_detent(); cw_detent(); cw_detent();
    flush();
    check("pre_reset", 5);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", 0);
    @(negedge clk);
    A = 1'b0;
    B = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    flush();
    check("post_reset_idle", 0);
    cw_detent();
    flush();
    check("post_reset_cw", 1);

    // Random pin activity against the model
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    // Biased walk so both saturation ends are exercised under random timing
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 8) cw_detent(); else ccw_detent();
    end
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 8) ccw_detent(); else cw_detent();
    end
    flush();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=2000000", $time);
    $fatal(1);
  end

endmodule
